unidade_controle: RTL
=====================

# unidade_controle

Multicycle control unit for the MIPS-subset processor. Sits directly upstream of the datapath: it consumes the Opcode and funct fields from the instruction register plus the ALU status flags (Igual, Overflow), and drives every datapath mux select, register load strobe and memory write each cycle. It sequences fetch, decode, execute, memory and writeback as a Moore FSM, with a Mealy branch-enable term only.

## Interface
- No parameters. State encoding and control encodings below are fixed.
- clock  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; forces state RESET on the next edge
- Opcode  in  6  instruction bits 31:26 from the instruction register
- Funct  in  6  instruction bits 5:0
- Igual  in  1  Ula32 equality flag (A==B)
- Overflow  in  1  Ula32 signed-overflow flag
- PCWrite  out  1  PC register load
- IorD  out  1  memory address select: 0=PC, 1=AluOut
- MemWrite  out  1  memory write enable (wr)
- IRWrite  out  1  instruction register load
- MDRWrite  out  1  memory data register load
- ABWrite  out  1  load A/B from register bank
- RegWrite  out  1  register bank write
- RegDst  out  2  write register: 00=rt, 01=rd
- MemToReg  out  2  write data: 00=AluOut, 01=MDR
- AluSrcA  out  1  0=PC, 1=A
- AluSrcB  out  2  00=B, 01=const 4, 10=signext(imm), 11=signext(imm)<<2
- AluOp  out  3  Ula32 Seletor: 000 pass A, 001 add, 010 sub, 011 and, 111 compare
- AluOutWrite  out  1  AluOut register load
- PCSource  out  2  00=ALU result, 01=AluOut, 10=jump target, 11=exception vector 0x0000_0080
- EPCWrite  out  1  EPC load from ALU result
- Estado  out  6  current state code, zero-extended by the datapath for debug

## Operation
- States/codes: RESET 0, FETCH 1, FETCH_WAIT 2, DECODE 3, R_EXEC 4, R_WB 5, JR 6, ADDI_EXEC 7, ADDI_WB 8, MEM_ADDR 9, LW_READ 10, LW_WAIT 11, LW_WB 12, SW_WRITE 13, BRANCH 14, JUMP 15, EXC 16. Unused codes go to RESET.
- Every output not listed for a state is 0.
- RESET: no strobes -> FETCH.
- FETCH: IorD=0, AluSrcA=0, AluSrcB=01, AluOp=001, PCSource=00, PCWrite=1 (PC<=PC+4) -> FETCH_WAIT.
- FETCH_WAIT: IorD=0, IRWrite=1 -> DECODE.
- DECODE: ABWrite=1, AluSrcA=0, AluSrcB=11, AluOp=001, AluOutWrite=1 (branch target). Dispatch: 0x00 with funct 0x20/0x22/0x24 -> R_EXEC; funct 0x08 -> JR; 0x08 -> ADDI_EXEC; 0x23/0x2B -> MEM_ADDR; 0x04/0x05 -> BRANCH; 0x02 -> JUMP; anything else -> EXC.
- R_EXEC: AluSrcA=1, AluSrcB=00, AluOp 001/010/011 for add/sub/and, AluOutWrite=1. Overflow=1 on add/sub -> EXC, else R_WB. `and` ignores Overflow.
- R_WB: RegDst=01, MemToReg=00, RegWrite=1 -> FETCH.
- JR: AluSrcA=1, AluOp=000, PCSource=00, PCWrite=1 -> FETCH.
- ADDI_EXEC: AluSrcA=1, AluSrcB=10, AluOp=001, AluOutWrite=1. Overflow -> EXC, else ADDI_WB.
- ADDI_WB: RegDst=00, MemToReg=00, RegWrite=1 -> FETCH.
- MEM_ADDR: AluSrcA=1, AluSrcB=10, AluOp=001, AluOutWrite=1 -> LW_READ (0x23) or SW_WRITE (0x2B).
- LW_READ: IorD=1 -> LW_WAIT. LW_WAIT: IorD=1, MDRWrite=1 -> LW_WB. LW_WB: RegDst=00, MemToReg=01, RegWrite=1 -> FETCH.
- SW_WRITE: IorD=1, MemWrite=1 -> FETCH.
- BRANCH: AluSrcA=1, AluSrcB=00, AluOp=111, PCSource=01. PCWrite=Igual for beq and !Igual for bne (only combinational output term). -> FETCH.
- JUMP: PCSource=10, PCWrite=1 -> FETCH.
- EXC: AluSrcA=0, AluSrcB=01, AluOp=010, EPCWrite=1 (EPC<=PC-4, the faulting instruction), PCSource=11, PCWrite=1 -> FETCH. No register or memory write occurs for a faulting instruction.

## Timing
- Reset is sampled on the rising edge. On the edge after reset is asserted: state=RESET, Estado=0, all outputs 0. Reset wins over any transition, including mid-instruction; a pending RegWrite/MemWrite state is abandoned.
- Memory read latency is 2 cycles (address, then wait). IR is valid from the cycle after FETCH_WAIT. MDR is valid from the cycle after LW_WAIT.
- Cycles per instruction: R-type 5, jr 4, addi 5, lw 7, sw 5, beq/bne 4, j 4, overflow 5, illegal opcode 4.
- Opcode/Funct are read only in DECODE, R_EXEC, MEM_ADDR and BRANCH. IR is stable in those cycles.

## Test plan
- Reset held 3 cycles, then released -> Estado 0, then 1, 2, 3 on successive cycles. All strobes 0 during reset.
- add (Opcode 0x00, Funct 0x20), Overflow=0 -> states 1,2,3,4,5. RegWrite=1 and RegDst=01 only in state 5.
- lw (0x23) -> states 1,2,3,9,10,11,12. MDRWrite in state 11. MemToReg=01 and RegWrite in state 12.
- beq (0x04) with Igual=1 -> PCWrite=1, PCSource=01 in state 14. Same instruction with Igual=0 -> PCWrite=0. bne inverts both cases.
- addi (0x08) with Overflow=1 in state 7 -> next state 16: EPCWrite=1, PCSource=11, AluOp=010, no RegWrite. Then state 1.
- Opcode 0x3F -> DECODE then EXC. Reset asserted in state 12 -> state 0 next cycle with RegWrite=0.

Source files
------------

// File: rtl/unidade_controle.sv
// Multicycle control unit for the MIPS-subset datapath: Moore FSM sequencing
// fetch/decode/execute/memory/writeback, with a single Mealy branch-enable term.
module unidade_controle (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] Opcode,
  input  logic [5:0] Funct,
  input  logic       Igual,
  input  logic       Overflow,
  output logic       PCWrite,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MDRWrite,
  output logic       ABWrite,
  output logic       RegWrite,
  output logic [1:0] RegDst,
  output logic [1:0] MemToReg,
  output logic       AluSrcA,
  output logic [1:0] AluSrcB,
  output logic [2:0] AluOp,
  output logic       AluOutWrite,
  output logic [1:0] PCSource,
  output logic       EPCWrite,
  output logic [5:0] Estado
);

  typedef enum logic [5:0] {
    S_RESET      = 6'd0,
    S_FETCH      = 6'd1,
    S_FETCH_WAIT = 6'd2,
    S_DECODE     = 6'd3,
    S_R_EXEC     = 6'd4,
    S_R_WB       = 6'd5,
    S_JR         = 6'd6,
    S_ADDI_EXEC  = 6'd7,
    S_ADDI_WB    = 6'd8,
    S_MEM_ADDR   = 6'd9,
    S_LW_READ    = 6'd10,
    S_LW_WAIT    = 6'd11,
    S_LW_WB      = 6'd12,
    S_SW_WRITE   = 6'd13,
    S_BRANCH     = 6'd14,
    S_JUMP       = 6'd15,
    S_EXC        = 6'd16
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;

  state_t state;
  state_t state_next;

  always_ff @(posedge clock) begin
    if (reset) state <= S_RESET;
    else       state <= state_next;
  end

  assign Estado = state;

  always_comb begin
    state_next  = S_RESET;
    PCWrite     = 1'b0;
    IorD        = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MDRWrite    = 1'b0;
    ABWrite     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 2'b00;
    MemToReg    = 2'b00;
    AluSrcA     = 1'b0;
    AluSrcB     = 2'b00;
    AluOp       = 3'b000;
    AluOutWrite = 1'b0;
    PCSource    = 2'b00;
    EPCWrite    = 1'b0;

    case (state)
      S_RESET: state_next = S_FETCH;
      S_FETCH: begin
        AluSrcB    = 2'b01;
        AluOp      = 3'b001;
        PCWrite    = 1'b1;
        state_next = S_FETCH_WAIT;
      end
      S_FETCH_WAIT: begin
        IRWrite    = 1'b1;
        state_next = S_DECODE;
      end
      S_DECODE: begin
        // AluOut speculatively holds the branch target for BRANCH
        ABWrite     = 1'b1;
        AluSrcB     = 2'b11;
        AluOp       = 3'b001;
        AluOutWrite = 1'b1;
        case (Opcode)
          OP_RTYPE: begin
            if (Funct == FN_ADD || Funct == FN_SUB || Funct == FN_AND) state_next = S_R_EXEC;
            else if (Funct == FN_JR)                                   state_next = S_JR;
            else                                                       state_next = S_EXC;
          end
          OP_ADDI:       state_next = S_ADDI_EXEC;
          OP_LW, OP_SW:  state_next = S_MEM_ADDR;
          OP_BEQ, OP_BNE: state_next = S_BRANCH;
          OP_J:          state_next = S_JUMP;
          default:       state_next = S_EXC;
        endcase
      end
      S_R_EXEC: begin
        AluSrcA     = 1'b1;
        AluOutWrite = 1'b1;
        if (Funct == FN_AND) begin
          AluOp      = 3'b011;
          state_next = S_R_WB;
        end else begin
          AluOp      = (Funct == FN_SUB) ? 3'b010 : 3'b001;
          state_next = Overflow ? S_EXC : S_R_WB;
        end
      end
      S_R_WB: begin
        RegDst     = 2'b01;
        RegWrite   = 1'b1;
        state_next = S_FETCH;
      end
      S_JR: begin
        AluSrcA    = 1'b1;
        PCWrite    = 1'b1;
        state_next = S_FETCH;
      end
      S_ADDI_EXEC: begin
        AluSrcA     = 1'b1;
        AluSrcB     = 2'b10;
        AluOp       = 3'b001;
        AluOutWrite = 1'b1;
        state_next  = Overflow ? S_EXC : S_ADDI_WB;
      end
      S_ADDI_WB: begin
        RegWrite   = 1'b1;
        state_next = S_FETCH;
      end
      S_MEM_ADDR: begin
        AluSrcA     = 1'b1;
        AluSrcB     = 2'b10;
        AluOp       = 3'b001;
        AluOutWrite = 1'b1;
        state_next  = (Opcode == OP_LW) ? S_LW_READ : S_SW_WRITE;
      end
      S_LW_READ: begin
        IorD       = 1'b1;
        state_next = S_LW_WAIT;
      end
      S_LW_WAIT: begin
        IorD       = 1'b1;
        MDRWrite   = 1'b1;
        state_next = S_LW_WB;
      end
      S_LW_WB: begin
        MemToReg   = 2'b01;
        RegWrite   = 1'b1;
        state_next = S_FETCH;
      end
      S_SW_WRITE: begin
        IorD       = 1'b1;
        MemWrite   = 1'b1;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        // The only input-dependent output: taken-branch PC load
        AluSrcA    = 1'b1;
        AluOp      = 3'b111;
        PCSource   = 2'b01;
        PCWrite    = (Opcode == OP_BNE) ? ~Igual : Igual;
        state_next = S_FETCH;
      end
      S_JUMP: begin
        PCSource   = 2'b10;
        PCWrite    = 1'b1;
        state_next = S_FETCH;
      end
      S_EXC: begin
        // PC already advanced past the faulting instruction; EPC gets PC-4
        AluSrcB    = 2'b01;
        AluOp      = 3'b010;
        EPCWrite   = 1'b1;
        PCSource   = 2'b11;
        PCWrite    = 1'b1;
        state_next = S_FETCH;
      end
      default: state_next = S_RESET;
    endcase
  end

endmodule
